neopixel_strand_ctrl_v2: RTL and testbench

- Parametrised successor to the single-strand NeoPixel driver.
- Holds GRB colour data for NUM_PIXELS pixels in a double-buffered frame store. Loads go to a shadow buffer at any time, including mid-frame.
- On send_it, snapshots the shadow buffer into the active buffer and serialises it onto one WS2812 data line, then enforces the latch gap.
- Bit timing is set by parameters, not hard-coded for 50 MHz.

---
 rtl/neopixel_strand_ctrl_v2.sv | 185 ++++++++++++++++++
 tb/tb_neopixel_strand_ctrl_v2.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/neopixel_strand_ctrl_v2.sv
// neopixel_strand_ctrl_v2: double-buffered GRB frame store serialised onto a
// single WS2812 data line with parameterised bit timing and a latch gap.
// Optional macro NEO_BRIGHTNESS_EN adds a brightness[7:0] input that scales
// each transmitted byte by (brightness+1)/256; stored bytes stay unscaled.
module neopixel_strand_ctrl_v2 #(
  parameter  int NUM_PIXELS   = 5,
  parameter  int T1H          = 35,
  parameter  int T1L          = 30,
  parameter  int T0H          = 18,
  parameter  int T0L          = 40,
  parameter  int LATCH_CYCLES = 2500,
  localparam int PIX_W        = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [7:0]       color_level,
  input  logic [1:0]       color_index,
  input  logic [PIX_W-1:0] pixel_index,
  input  logic             load_color,
  input  logic             send_it,
`ifdef NEO_BRIGHTNESS_EN
  input  logic [7:0]       brightness,
`endif
  output logic             neo_data,
  output logic             ready_to_load,
  output logic             ready_to_send,
  output logic             frame_done
);

  localparam int MAX_A = (T1H > T1L) ? T1H : T1L;
  localparam int MAX_B = (T0H > T0L) ? T0H : T0L;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAXC  = (MAX_C > LATCH_CYCLES) ? MAX_C : LATCH_CYCLES;
  localparam int CNT_W = $clog2(MAXC) + 1;
  localparam int NBITS = 24 * NUM_PIXELS;
  localparam int BIT_W = $clog2(NBITS);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

  state_t                     state, state_n;
  logic [CNT_W-1:0]           cyc_cnt, cyc_n;
  logic [BIT_W-1:0]           bit_cnt, bit_n;
  logic [PIX_W-1:0]           pix_cnt, pix_n;
  logic [4:0]                 sub_cnt, sub_n;
  logic [NUM_PIXELS-1:0][23:0] shadow, active;
  logic                       accept, done_n, load_ok, cur_bit;
  logic [23:0]                cur_word;
  logic [7:0]                 raw_byte, tx_byte;
  logic [CNT_W-1:0]           hi_len, lo_len;

  assign ready_to_load = 1'b1;
  assign load_ok = load_color && (color_index != 2'd3) &&
                   (int'(pixel_index) < NUM_PIXELS);

  // Pick the byte under the bit pointer: G, R, B order, MSB first.
  assign cur_word = active[pix_cnt];
  always_comb begin
    raw_byte = cur_word[7:0];
    case (sub_cnt[4:3])
      2'd0:    raw_byte = cur_word[23:16];
      2'd1:    raw_byte = cur_word[15:8];
      default: raw_byte = cur_word[7:0];
    endcase
  end

`ifdef NEO_BRIGHTNESS_EN
  logic [7:0]  bright_q;
  logic [16:0] prod;
  assign prod    = {9'd0, raw_byte} * ({9'd0, bright_q} + 17'd1);
  assign tx_byte = prod[15:8];

  // Brightness is frozen at send acceptance for the whole frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    bright_q <= 8'd0;
    else if (accept) bright_q <= brightness;
  end
`else
  assign tx_byte = raw_byte;
`endif

  assign cur_bit = tx_byte[~sub_cnt[2:0]];
  assign hi_len  = cur_bit ? CNT_W'(T1H) : CNT_W'(T0H);
  assign lo_len  = cur_bit ? CNT_W'(T1L) : CNT_W'(T0L);

  // Next-state, counter and bit-pointer logic for the serialiser.
  always_comb begin
    state_n = state;
    cyc_n   = cyc_cnt;
    bit_n   = bit_cnt;
    pix_n   = pix_cnt;
    sub_n   = sub_cnt;
    done_n  = 1'b0;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (send_it) begin
          accept  = 1'b1;
          state_n = HIGH;
          cyc_n   = '0;
          bit_n   = '0;
          pix_n   = '0;
          sub_n   = '0;
        end
      end
      HIGH: begin
        if (cyc_cnt == hi_len - 1'b1) begin
          state_n = LOW;
          cyc_n   = '0;
        end else begin
          cyc_n = cyc_cnt + 1'b1;
        end
      end
      LOW: begin
        if (cyc_cnt == lo_len - 1'b1) begin
          cyc_n = '0;
          if (bit_cnt == BIT_W'(NBITS - 1)) begin
            state_n = LATCH;
          end else begin
            state_n = HIGH;
            bit_n   = bit_cnt + 1'b1;
            if (sub_cnt == 5'd23) begin
              sub_n = '0;
              pix_n = pix_cnt + 1'b1;
            end else begin
              sub_n = sub_cnt + 1'b1;
            end
          end
        end else begin
          cyc_n = cyc_cnt + 1'b1;
        end
      end
      LATCH: begin
        if (cyc_cnt == CNT_W'(LATCH_CYCLES - 1)) begin
          state_n = IDLE;
          cyc_n   = '0;
          done_n  = 1'b1;
        end else begin
          cyc_n = cyc_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters and registered outputs; data line is high only in HIGH.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cyc_cnt       <= '0;
      bit_cnt       <= '0;
      pix_cnt       <= '0;
      sub_cnt       <= '0;
      neo_data      <= 1'b0;
      ready_to_send <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      state         <= state_n;
      cyc_cnt       <= cyc_n;
      bit_cnt       <= bit_n;
      pix_cnt       <= pix_n;
      sub_cnt       <= sub_n;
      neo_data      <= (state_n == HIGH);
      ready_to_send <= (state_n == IDLE);
      frame_done    <= done_n;
    end
  end

  // Shadow takes loads any time; active snapshots pre-edge shadow on accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (accept) active <= shadow;
      if (load_ok) begin
        case (color_index)
          2'd0:    shadow[pixel_index][15:8]  <= color_level;
          2'd1:    shadow[pixel_index][7:0]   <= color_level;
          default: shadow[pixel_index][23:16] <= color_level;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_neopixel_strand_ctrl_v2.sv
// Self-checking bench for neopixel_strand_ctrl_v2: directed plus random loads,
// each frame decoded from neo_data pulse widths against a colour-array model.
module tb_neopixel_strand_ctrl_v2;
  localparam int N = 5, NB = 24 * N;
  localparam int T1H = 35, T1L = 30, T0H = 18, T0L = 40, LAT = 2500;

  logic       clock = 1'b0, reset_n = 1'b0;
  logic [7:0] color_level = '0;
  logic [1:0] color_index = '0;
  logic [2:0] pixel_index = '0;
  logic       load_color = 1'b0, send_it = 1'b0;
  logic       neo_data, ready_to_load, ready_to_send, frame_done;
`ifdef NEO_BRIGHTNESS_EN
  logic [7:0] brightness = 8'hFF;
`endif

  int n_chk = 0, n_fail = 0;
  int mg[N], mr[N], mb[N];
  int exp_bits[NB];
  bit midload = 0, spam = 0;
  int rx0;

  always #5 clock = ~clock;

  neopixel_strand_ctrl_v2 dut (
    .clock(clock), .reset_n(reset_n), .color_level(color_level),
    .color_index(color_index), .pixel_index(pixel_index),
    .load_color(load_color), .send_it(send_it),
`ifdef NEO_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .neo_data(neo_data), .ready_to_load(ready_to_load),
    .ready_to_send(ready_to_send), .frame_done(frame_done));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void mload(int p, int c, int v);
    if (p < N && c != 3) begin
      if (c == 0) mr[p] = v;
      else if (c == 1) mb[p] = v;
      else mg[p] = v;
    end
  endfunction

  function automatic void mclear();
    for (int p = 0; p < N; p++) begin mg[p] = 0; mr[p] = 0; mb[p] = 0; end
  endfunction

  // Expected frame: pixel 0 first, G,R,B bytes, MSB first, optionally scaled.
  function automatic void snapshot();
    int br, v;
    br = 255;
`ifdef NEO_BRIGHTNESS_EN
    br = int'(brightness);
`endif
    for (int p = 0; p < N; p++)
      for (int k = 0; k < 3; k++) begin
        v = (k == 0) ? mg[p] : (k == 1) ? mr[p] : mb[p];
        v = (v * (br + 1)) / 256;
        for (int j = 0; j < 8; j++) exp_bits[p*24 + k*8 + j] = (v >> (7 - j)) & 1;
      end
  endfunction

  task automatic do_load(input int p, input int c, input int v);
    pixel_index = p[2:0]; color_index = c[1:0]; color_level = v[7:0];
    load_color = 1'b1;
    @(negedge clock);
    load_color = 1'b0;
    mload(p, c, v);
  endtask

  task automatic do_send(input bit wl, input int p, input int c, input int v);
    check("rts_before_send", ready_to_send, 1);
    send_it = 1'b1;
    if (wl) begin
      pixel_index = p[2:0]; color_index = c[1:0]; color_level = v[7:0];
      load_color = 1'b1;
    end
    snapshot();
    if (wl) mload(p, c, v);
    @(negedge clock);
    send_it = 1'b0; load_color = 1'b0;
    check("neo_rise_after_accept", neo_data, 1);
    check("rts_drop_after_accept", ready_to_send, 0);
  endtask

  // Measure every bit's high/low width; last low includes the latch gap.
  task automatic recv_frame(input int reset_at);
    int hi, lo, eh, el;
    rx0 = 0;
    send_it = spam;
    for (int i = 0; i < NB; i++) begin
      if (i == reset_at) begin
        reset_n = 1'b0; send_it = 1'b0;
        #1;
        check("abort_neo_low", neo_data, 0);
        check("abort_rts_low", ready_to_send, 0);
        check("abort_done_low", frame_done, 0);
        return;
      end
      if (midload && i == 10) begin
        pixel_index = 3'd0; color_index = 2'd2; color_level = 8'hFF;
        load_color = 1'b1;
        mload(0, 2, 255);
      end
      hi = 0;
      while (neo_data === 1'b1 && hi < 200) begin
        hi++; @(negedge clock); load_color = 1'b0;
      end
      lo = 0;
      while (neo_data === 1'b0 && frame_done !== 1'b1 && lo < 4000) begin
        lo++; @(negedge clock);
      end
      eh = exp_bits[i] ? T1H : T0H;
      el = (exp_bits[i] ? T1L : T0L) + ((i == NB - 1) ? LAT : 0);
      check($sformatf("bit%0d_high", i), hi, eh);
      check($sformatf("bit%0d_low", i), lo, el);
      if (i < 8) rx0 = (rx0 << 1) | ((hi == T1H) ? 1 : 0);
      if (hi == 0 || hi == 200 || lo == 4000) begin
        send_it = 1'b0; load_color = 1'b0;
        return;
      end
    end
    check("frame_done_pulse", frame_done, 1);
    check("rts_at_done", ready_to_send, 1);
    check("neo_low_at_done", neo_data, 0);
    send_it = 1'b0;
    @(negedge clock);
    check("frame_done_one_cycle", frame_done, 0);
  endtask

  initial begin
    mclear();
    // Reset state
    repeat (3) @(negedge clock);
    check("rst_neo", neo_data, 0);
    check("rst_rts", ready_to_send, 0);
    check("rst_done", frame_done, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check("post_rst_rts", ready_to_send, 1);
    check("post_rst_neo", neo_data, 0);
    check("ready_to_load", ready_to_load, 1);

    // Frame 1: single 1-bit at the start
    do_load(0, 2, 8'h80);
    do_send(0, 0, 0, 0);
    recv_frame(-1);

    // Frame 2: pattern, with a mid-frame load of pixel 0 G=FF at bit 10
    do_load(0, 2, 0);
    do_load(2, 0, 8'hA5);
    do_load(4, 1, 8'h01);
    midload = 1;
    do_send(0, 0, 0, 0);
    recv_frame(-1);
    midload = 0;

    // Ignored loads, then send with same-cycle load while spamming send_it
    do_load(7, 0, 8'hAA);
    do_load(5, 2, 8'h3C);
    do_load(1, 3, 8'h77);
    spam = 1;
    do_send(1, 1, 0, 8'h55);
    recv_frame(-1);
    spam = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check("no_second_frame_neo", neo_data, 0);
      check("no_second_frame_rts", ready_to_send, 1);
    end

    // Random loads (including out-of-range ones), frame shows 55 too
    for (int k = 0; k < 12; k++)
      do_load($urandom_range(7), $urandom_range(3), $urandom_range(255));
    do_send(0, 0, 0, 0);
    recv_frame(-1);

    // Random loads, then reset at bit 50
    for (int k = 0; k < 8; k++)
      do_load($urandom_range(7), $urandom_range(3), $urandom_range(255));
    do_send(0, 0, 0, 0);
    recv_frame(50);
    repeat (3) @(negedge clock);
    check("in_rst_neo", neo_data, 0);
    check("in_rst_rts", ready_to_send, 0);
    reset_n = 1'b1;
    mclear();
    repeat (2) @(negedge clock);
    check("rerst_rts", ready_to_send, 1);
    check("rerst_neo", neo_data, 0);

    // Fresh frame after reset: all zeros
    do_send(0, 0, 0, 0);
    recv_frame(-1);

`ifdef NEO_BRIGHTNESS_EN
    do_load(0, 2, 8'hC8);
    brightness = 8'h7F;
    do_send(0, 0, 0, 0);
    recv_frame(-1);
    check("bright_scaled_g", rx0, 32'h64);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
